// File: rtl/ahb_pkg.sv
// -----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB definitions for the two-master arbiter slice:
//   - htrans_e      : HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   - mst_idx_t     : master index (one bit, two masters)
//   - addr_phase_t  : one captured address phase (addr + control)
//   - trans_active  : true for NONSEQ/SEQ, i.e. a real transfer request
//   - rr_pick       : two-way round-robin choice, last winner loses ties
// -----------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef logic mst_idx_t;

    typedef struct packed {
        logic [31:0] addr;
        htrans_e     trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
    } addr_phase_t;

    function automatic logic trans_active(input htrans_e t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

    // The master that did not win last time is preferred; with no request
    // at all the bus parks on the given master.
    function automatic mst_idx_t rr_pick(input logic [1:0] req,
                                         input mst_idx_t   last,
                                         input mst_idx_t   park);
        mst_idx_t other;
        other = ~last;
        if (req[other]) begin
            return other;
        end else if (req[last]) begin
            return last;
        end else begin
            return park;
        end
    endfunction

endpackage

// File: rtl/ahb_input_stage.sv
// -----------------------------------------------------------------------------
// ahb_input_stage
// Per-master skid register. When the master believes its address phase was
// accepted (HREADY_Mx=1) but the bus did not take it this cycle, the phase is
// captured here and replayed once the arbiter grants this master.
// Ports:
//   clk_i        : clock
//   rst_i        : synchronous active-high reset (drops any held phase)
//   live_i       : address phase currently driven by the master
//   hready_m_i   : HREADY as seen by this master
//   issue_i      : bus takes this master's selected phase this cycle (HREADY=1)
//   phase_o      : held phase when one is pending, otherwise live_i
//   hold_valid_o : a captured phase is pending
// -----------------------------------------------------------------------------
module ahb_input_stage
    import ahb_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  addr_phase_t live_i,
    input  logic        hready_m_i,
    input  logic        issue_i,
    output addr_phase_t phase_o,
    output logic        hold_valid_o
);

    addr_phase_t hold_q;
    addr_phase_t hold_d;
    logic        hold_valid_q;
    logic        hold_valid_d;

    // Capture / release decision for the held address phase.
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (hold_valid_q) begin
            // Live inputs are ignored while a phase is held.
            if (issue_i) begin
                hold_valid_d = 1'b0;
            end else begin
                hold_valid_d = 1'b1;
            end
        end else begin
            if (trans_active(live_i.trans) && hready_m_i && !issue_i) begin
                hold_valid_d = 1'b1;
                hold_d       = live_i;
            end else begin
                hold_valid_d = 1'b0;
            end
        end
    end

    // Held phase registers; reset abandons anything pending.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end

    assign phase_o      = hold_valid_q ? hold_q : live_i;
    assign hold_valid_o = hold_valid_q;

endmodule

// File: rtl/ahb_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_arbiter
// Two-master AHB arbiter/multiplexer with a skid stage per master.
// The granted master's address phase passes combinationally to the shared
// bus; a losing master's phase is captured and replayed later.
// Ports:
//   HCLK, HRESET                 : clock, synchronous active-high reset
//   H*_M0 / H*_M1 (inputs)       : master address/control/write data
//   HRDATA_Mx/HREADY_Mx/HRESP_Mx : per-master response
//   HADDR..HWDATA (outputs)      : shared bus toward the interconnect
//   HRDATA/HREADY/HRESP (inputs) : shared bus response
//   HMASTER                      : master owning the current address phase
// -----------------------------------------------------------------------------
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned PARK_MASTER = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] HADDR_M0,
    input  logic [31:0] HADDR_M1,
    input  logic [1:0]  HTRANS_M0,
    input  logic [1:0]  HTRANS_M1,
    input  logic        HWRITE_M0,
    input  logic        HWRITE_M1,
    input  logic [2:0]  HSIZE_M0,
    input  logic [2:0]  HSIZE_M1,
    input  logic [2:0]  HBURST_M0,
    input  logic [2:0]  HBURST_M1,
    input  logic [3:0]  HPROT_M0,
    input  logic [3:0]  HPROT_M1,
    input  logic        HMASTLOCK_M0,
    input  logic        HMASTLOCK_M1,
    input  logic [31:0] HWDATA_M0,
    input  logic [31:0] HWDATA_M1,
    output logic [31:0] HRDATA_M0,
    output logic [31:0] HRDATA_M1,
    output logic        HREADY_M0,
    output logic        HREADY_M1,
    output logic        HRESP_M0,
    output logic        HRESP_M1,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        HMASTER
);

    localparam mst_idx_t PARK_IDX = (PARK_MASTER != 0) ? 1'b1 : 1'b0;

    addr_phase_t live_m0_s;
    addr_phase_t live_m1_s;
    addr_phase_t phase_m0_s;
    addr_phase_t phase_m1_s;
    addr_phase_t bus_phase_s;
    htrans_e     bus_trans_s;
    logic        hold_m0_s;
    logic        hold_m1_s;
    logic [1:0]  req_s;
    logic        issued_s;
    logic        issue_m0_s;
    logic        issue_m1_s;
    logic        keep_s;
    mst_idx_t    eff_last_s;

    mst_idx_t    grant_q;
    mst_idx_t    grant_d;
    mst_idx_t    last_q;
    mst_idx_t    last_d;
    mst_idx_t    dp_owner_q;
    mst_idx_t    dp_owner_d;
    logic        dp_valid_q;
    logic        dp_valid_d;

    assign live_m0_s = '{addr: HADDR_M0, trans: htrans_e'(HTRANS_M0), write: HWRITE_M0,
                         size: HSIZE_M0, burst: HBURST_M0, prot: HPROT_M0, lock: HMASTLOCK_M0};
    assign live_m1_s = '{addr: HADDR_M1, trans: htrans_e'(HTRANS_M1), write: HWRITE_M1,
                         size: HSIZE_M1, burst: HBURST_M1, prot: HPROT_M1, lock: HMASTLOCK_M1};

    ahb_input_stage u_stage_m0 (
        .clk_i        (HCLK),
        .rst_i        (HRESET),
        .live_i       (live_m0_s),
        .hready_m_i   (HREADY_M0),
        .issue_i      (issue_m0_s),
        .phase_o      (phase_m0_s),
        .hold_valid_o (hold_m0_s)
    );

    ahb_input_stage u_stage_m1 (
        .clk_i        (HCLK),
        .rst_i        (HRESET),
        .live_i       (live_m1_s),
        .hready_m_i   (HREADY_M1),
        .issue_i      (issue_m1_s),
        .phase_o      (phase_m1_s),
        .hold_valid_o (hold_m1_s)
    );

    // Address-phase mux: the selected phase is already held-or-live, so its
    // transfer type doubles as the request line.
    always_comb begin
        req_s[0]    = trans_active(phase_m0_s.trans);
        req_s[1]    = trans_active(phase_m1_s.trans);
        bus_phase_s = (grant_q == 1'b1) ? phase_m1_s : phase_m0_s;
        if (HRESET || (req_s == 2'b00)) begin
            bus_trans_s = HTRANS_IDLE;
        end else begin
            bus_trans_s = bus_phase_s.trans;
        end
        issued_s   = trans_active(bus_trans_s);
        issue_m0_s = issued_s && HREADY && (grant_q == 1'b0);
        issue_m1_s = issued_s && HREADY && (grant_q == 1'b1);
    end

    // Arbitration and data-phase tracking, advanced only when HREADY=1.
    always_comb begin
        grant_d    = grant_q;
        last_d     = last_q;
        dp_owner_d = dp_owner_q;
        dp_valid_d = dp_valid_q;
        // A master that issues this cycle becomes the last winner.
        eff_last_s = issued_s ? grant_q : last_q;
        keep_s     = (bus_trans_s == HTRANS_SEQ) || (issued_s && bus_phase_s.lock);
        if (HREADY) begin
            last_d     = eff_last_s;
            dp_owner_d = grant_q;
            dp_valid_d = issued_s;
            if (keep_s) begin
                grant_d = grant_q;
            end else begin
                grant_d = rr_pick(req_s, eff_last_s, PARK_IDX);
            end
        end else begin
            grant_d = grant_q;
        end
    end

    // Arbiter state; last_q=1 after reset makes M0 win the first tie.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_q    <= PARK_IDX;
            last_q     <= 1'b1;
            dp_owner_q <= PARK_IDX;
            dp_valid_q <= 1'b0;
        end else begin
            grant_q    <= grant_d;
            last_q     <= last_d;
            dp_owner_q <= dp_owner_d;
            dp_valid_q <= dp_valid_d;
        end
    end

    // Per-master response: data-phase owner sees the bus, a master with a
    // pending held phase is stalled, everyone else sees ready.
    always_comb begin
        HREADY_M0 = 1'b1;
        HREADY_M1 = 1'b1;
        HRESP_M0  = 1'b0;
        HRESP_M1  = 1'b0;
        if (HRESET) begin
            HREADY_M0 = 1'b1;
            HREADY_M1 = 1'b1;
        end else begin
            if (dp_valid_q && (dp_owner_q == 1'b0)) begin
                HREADY_M0 = HREADY;
                HRESP_M0  = HRESP;
            end else if (hold_m0_s) begin
                HREADY_M0 = 1'b0;
            end else begin
                HREADY_M0 = 1'b1;
            end
            if (dp_valid_q && (dp_owner_q == 1'b1)) begin
                HREADY_M1 = HREADY;
                HRESP_M1  = HRESP;
            end else if (hold_m1_s) begin
                HREADY_M1 = 1'b0;
            end else begin
                HREADY_M1 = 1'b1;
            end
        end
    end

    assign HADDR     = bus_phase_s.addr;
    assign HTRANS    = bus_trans_s;
    assign HWRITE    = bus_phase_s.write;
    assign HSIZE     = bus_phase_s.size;
    assign HBURST    = bus_phase_s.burst;
    assign HPROT     = bus_phase_s.prot;
    assign HMASTLOCK = bus_phase_s.lock;
    assign HMASTER   = HRESET ? PARK_IDX : grant_q;
    assign HWDATA    = (dp_owner_q == 1'b1) ? HWDATA_M1 : HWDATA_M0;
    assign HRDATA_M0 = HRDATA;
    assign HRDATA_M1 = HRDATA;

endmodule

// File: tb/tb_ahb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ahb_arbiter
// Directed bench for ahb_arbiter: reset state, single master pass-through,
// first-cycle contention, alternating back-to-back traffic, locked sequence,
// held write with slave wait states, and reset while a phase is held.
// -----------------------------------------------------------------------------
module tb_ahb_arbiter;

    logic        HCLK;
    logic        HRESET;
    logic [31:0] HADDR_M0, HADDR_M1;
    logic [1:0]  HTRANS_M0, HTRANS_M1;
    logic        HWRITE_M0, HWRITE_M1;
    logic [2:0]  HSIZE_M0, HSIZE_M1;
    logic [2:0]  HBURST_M0, HBURST_M1;
    logic [3:0]  HPROT_M0, HPROT_M1;
    logic        HMASTLOCK_M0, HMASTLOCK_M1;
    logic [31:0] HWDATA_M0, HWDATA_M1;
    logic [31:0] HRDATA_M0, HRDATA_M1;
    logic        HREADY_M0, HREADY_M1;
    logic        HRESP_M0, HRESP_M1;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        HMASTER;

    int n_cmp;
    int n_err;

    ahb_arbiter #(.PARK_MASTER(0)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HADDR_M0(HADDR_M0), .HADDR_M1(HADDR_M1),
        .HTRANS_M0(HTRANS_M0), .HTRANS_M1(HTRANS_M1),
        .HWRITE_M0(HWRITE_M0), .HWRITE_M1(HWRITE_M1),
        .HSIZE_M0(HSIZE_M0), .HSIZE_M1(HSIZE_M1),
        .HBURST_M0(HBURST_M0), .HBURST_M1(HBURST_M1),
        .HPROT_M0(HPROT_M0), .HPROT_M1(HPROT_M1),
        .HMASTLOCK_M0(HMASTLOCK_M0), .HMASTLOCK_M1(HMASTLOCK_M1),
        .HWDATA_M0(HWDATA_M0), .HWDATA_M1(HWDATA_M1),
        .HRDATA_M0(HRDATA_M0), .HRDATA_M1(HRDATA_M1),
        .HREADY_M0(HREADY_M0), .HREADY_M1(HREADY_M1),
        .HRESP_M0(HRESP_M0), .HRESP_M1(HRESP_M1),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .HMASTER(HMASTER)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic [1:0] t, input logic [31:0] a, input logic w, input logic l);
        HTRANS_M0 = t; HADDR_M0 = a; HWRITE_M0 = w; HMASTLOCK_M0 = l;
    endtask

    task automatic set_m1(input logic [1:0] t, input logic [31:0] a, input logic w, input logic l);
        HTRANS_M1 = t; HADDR_M1 = a; HWRITE_M1 = w; HMASTLOCK_M1 = l;
    endtask

    task automatic idle_masters();
        set_m0(2'b00, 32'h0000_0000, 1'b0, 1'b0);
        set_m1(2'b00, 32'h0000_0000, 1'b0, 1'b0);
        HSIZE_M0 = 3'b010; HSIZE_M1 = 3'b010;
        HBURST_M0 = 3'b000; HBURST_M1 = 3'b000;
        HPROT_M0 = 4'b0011; HPROT_M1 = 4'b0011;
        HWDATA_M0 = 32'h0000_0000; HWDATA_M1 = 32'h0000_0000;
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic sample();
        @(negedge HCLK);
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        idle_masters();
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0000_0000;
        next_cycle();
        next_cycle();
        HRESET = 1'b0;
    endtask

    initial begin
        int k0;
        int k1;
        logic r0;
        logic r1;
        logic [31:0] ea;
        n_cmp = 0;
        n_err = 0;

        // ---------------- reset state ----------------
        do_reset();
        HRESET = 1'b1;
        HRESP  = 1'b1;
        set_m0(2'b10, 32'h0000_0040, 1'b0, 1'b0);
        sample();
        check_eq("rst_htrans",  {30'd0, HTRANS}, 32'd0);
        check_eq("rst_hmaster", {31'd0, HMASTER}, 32'd0);
        check_eq("rst_hready0", {31'd0, HREADY_M0}, 32'd1);
        check_eq("rst_hready1", {31'd0, HREADY_M1}, 32'd1);
        check_eq("rst_hresp0",  {31'd0, HRESP_M0}, 32'd0);
        check_eq("rst_hresp1",  {31'd0, HRESP_M1}, 32'd0);
        next_cycle();
        HRESET = 1'b0;
        idle_masters();
        sample();
        check_eq("post_rst_htrans",  {30'd0, HTRANS}, 32'd0);
        check_eq("post_rst_hready1", {31'd0, HREADY_M1}, 32'd1);
        check_eq("post_rst_hresp0",  {31'd0, HRESP_M0}, 32'd0);
        check_eq("post_rst_hmaster", {31'd0, HMASTER}, 32'd0);
        HRESP = 1'b0;

        // ---------------- M0 alone, zero latency ----------------
        do_reset();
        set_m0(2'b10, 32'h0000_0010, 1'b0, 1'b0);
        sample();
        check_eq("solo_haddr",   HADDR, 32'h0000_0010);
        check_eq("solo_htrans",  {30'd0, HTRANS}, 32'd2);
        check_eq("solo_hmaster", {31'd0, HMASTER}, 32'd0);
        check_eq("solo_hready0_a", {31'd0, HREADY_M0}, 32'd1);
        next_cycle();
        idle_masters();
        HREADY = 1'b0; HRESP = 1'b1; HRDATA = 32'hCAFE_F00D;
        sample();
        check_eq("solo_hready0_wait", {31'd0, HREADY_M0}, 32'd0);
        check_eq("solo_hresp0", {31'd0, HRESP_M0}, 32'd1);
        check_eq("solo_hresp1", {31'd0, HRESP_M1}, 32'd0);
        check_eq("solo_hready1", {31'd0, HREADY_M1}, 32'd1);
        check_eq("hrdata_m0", HRDATA_M0, 32'hCAFE_F00D);
        check_eq("hrdata_m1", HRDATA_M1, 32'hCAFE_F00D);
        next_cycle();
        HREADY = 1'b1; HRESP = 1'b0;
        sample();
        check_eq("solo_hready0_done", {31'd0, HREADY_M0}, 32'd1);
        next_cycle();
        HREADY = 1'b0;
        sample();
        check_eq("solo_hready0_nodp", {31'd0, HREADY_M0}, 32'd1);
        next_cycle();
        HREADY = 1'b1;

        // ---------------- simultaneous first request ----------------
        do_reset();
        set_m0(2'b10, 32'h0000_0100, 1'b0, 1'b0);
        set_m1(2'b10, 32'h2000_0000, 1'b0, 1'b0);
        sample();
        check_eq("tie_c0_hmaster", {31'd0, HMASTER}, 32'd0);
        check_eq("tie_c0_haddr", HADDR, 32'h0000_0100);
        check_eq("tie_c0_hready1", {31'd0, HREADY_M1}, 32'd1);
        next_cycle();
        idle_masters();
        sample();
        check_eq("tie_c1_hmaster", {31'd0, HMASTER}, 32'd1);
        check_eq("tie_c1_haddr", HADDR, 32'h2000_0000);
        check_eq("tie_c1_htrans", {30'd0, HTRANS}, 32'd2);
        check_eq("tie_c1_hready1", {31'd0, HREADY_M1}, 32'd0);
        check_eq("tie_c1_hready0", {31'd0, HREADY_M0}, 32'd1);
        next_cycle();
        HREADY = 1'b0;
        sample();
        check_eq("tie_c2_hready1", {31'd0, HREADY_M1}, 32'd0);
        check_eq("tie_c2_htrans", {30'd0, HTRANS}, 32'd0);
        next_cycle();
        HREADY = 1'b1;
        sample();
        check_eq("tie_c3_hready1", {31'd0, HREADY_M1}, 32'd1);
        next_cycle();

        // ---------------- continuous contention, 4 transfers each ----------------
        do_reset();
        k0 = 0;
        k1 = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            set_m0((k0 < 4) ? 2'b10 : 2'b00, 32'h1000_0000 + 32'(k0) * 32'd4, 1'b0, 1'b0);
            set_m1((k1 < 4) ? 2'b10 : 2'b00, 32'h2000_0000 + 32'(k1) * 32'd4, 1'b0, 1'b0);
            sample();
            ea = ((cyc % 2) == 0) ? (32'h1000_0000 + 32'(cyc / 2) * 32'd4)
                                  : (32'h2000_0000 + 32'(cyc / 2) * 32'd4);
            check_eq($sformatf("rr_hmaster_c%0d", cyc), {31'd0, HMASTER}, 32'(cyc % 2));
            check_eq($sformatf("rr_haddr_c%0d", cyc), HADDR, ea);
            r0 = HREADY_M0;
            r1 = HREADY_M1;
            next_cycle();
            if (r0 && (k0 < 4)) k0++;
            if (r1 && (k1 < 4)) k1++;
        end
        idle_masters();
        sample();
        check_eq("rr_m0_count", 32'(k0), 32'd4);
        check_eq("rr_m1_count", 32'(k1), 32'd4);
        check_eq("rr_hready1_last", {31'd0, HREADY_M1}, 32'd1);
        next_cycle();

        // ---------------- locked sequence from M1 ----------------
        do_reset();
        set_m1(2'b10, 32'h3000_0000, 1'b0, 1'b1);
        sample();
        check_eq("lk_c0_htrans", {30'd0, HTRANS}, 32'd0);
        check_eq("lk_c0_hready1", {31'd0, HREADY_M1}, 32'd1);
        next_cycle();
        set_m1(2'b10, 32'h3000_0004, 1'b1, 1'b1);
        set_m0(2'b10, 32'h0000_0200, 1'b0, 1'b0);
        sample();
        check_eq("lk_c1_hmaster", {31'd0, HMASTER}, 32'd1);
        check_eq("lk_c1_haddr", HADDR, 32'h3000_0000);
        check_eq("lk_c1_hmastlock", {31'd0, HMASTLOCK}, 32'd1);
        check_eq("lk_c1_hready1", {31'd0, HREADY_M1}, 32'd0);
        next_cycle();
        sample();
        check_eq("lk_c2_hmaster", {31'd0, HMASTER}, 32'd1);
        check_eq("lk_c2_haddr", HADDR, 32'h3000_0004);
        check_eq("lk_c2_hwrite", {31'd0, HWRITE}, 32'd1);
        check_eq("lk_c2_hready0", {31'd0, HREADY_M0}, 32'd0);
        next_cycle();
        set_m1(2'b00, 32'h0000_0000, 1'b0, 1'b0);
        sample();
        check_eq("lk_c3_hmaster", {31'd0, HMASTER}, 32'd1);
        check_eq("lk_c3_hready0", {31'd0, HREADY_M0}, 32'd0);
        next_cycle();
        set_m0(2'b00, 32'h0000_0000, 1'b0, 1'b0);
        sample();
        check_eq("lk_c4_hmaster", {31'd0, HMASTER}, 32'd0);
        check_eq("lk_c4_haddr", HADDR, 32'h0000_0200);
        check_eq("lk_c4_htrans", {30'd0, HTRANS}, 32'd2);
        next_cycle();
        sample();
        check_eq("lk_c5_hready0", {31'd0, HREADY_M0}, 32'd1);
        next_cycle();

        // ---------------- held write with slave wait states ----------------
        do_reset();
        set_m0(2'b10, 32'h0000_0300, 1'b1, 1'b0);
        set_m1(2'b10, 32'h3000_0000, 1'b1, 1'b0);
        sample();
        check_eq("wr_c0_hready1", {31'd0, HREADY_M1}, 32'd1);
        next_cycle();
        idle_masters();
        HWDATA_M0 = 32'h1111_1111;
        HWDATA_M1 = 32'hDEAD_BEEF;
        sample();
        check_eq("wr_c1_hmaster", {31'd0, HMASTER}, 32'd1);
        check_eq("wr_c1_haddr", HADDR, 32'h3000_0000);
        check_eq("wr_c1_hwrite", {31'd0, HWRITE}, 32'd1);
        check_eq("wr_c1_hwdata", HWDATA, 32'h1111_1111);
        check_eq("wr_c1_hready1", {31'd0, HREADY_M1}, 32'd0);
        next_cycle();
        HREADY = 1'b0;
        for (int w = 0; w < 3; w++) begin
            sample();
            check_eq($sformatf("wr_wait%0d_hwdata", w), HWDATA, 32'hDEAD_BEEF);
            check_eq($sformatf("wr_wait%0d_hready1", w), {31'd0, HREADY_M1}, 32'd0);
            next_cycle();
        end
        HREADY = 1'b1;
        sample();
        check_eq("wr_done_hwdata", HWDATA, 32'hDEAD_BEEF);
        check_eq("wr_done_hready1", {31'd0, HREADY_M1}, 32'd1);
        next_cycle();

        // ---------------- reset while M1 holds a phase ----------------
        do_reset();
        set_m0(2'b10, 32'h0000_0100, 1'b0, 1'b0);
        set_m1(2'b10, 32'h2000_0000, 1'b0, 1'b0);
        sample();
        next_cycle();
        idle_masters();
        HRESET = 1'b1;
        sample();
        check_eq("rh_during_htrans", {30'd0, HTRANS}, 32'd0);
        check_eq("rh_during_hready1", {31'd0, HREADY_M1}, 32'd1);
        next_cycle();
        HRESET = 1'b0;
        sample();
        check_eq("rh_after_htrans", {30'd0, HTRANS}, 32'd0);
        check_eq("rh_after_hready1", {31'd0, HREADY_M1}, 32'd1);
        check_eq("rh_after_hmaster", {31'd0, HMASTER}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            sample();
            check_eq($sformatf("rh_noreplay%0d_htrans", c), {30'd0, HTRANS}, 32'd0);
        end
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
